bike_encoder: RTL

Sequential encapsulation-side encoder for the BIKE-style KEM. It computes the ciphertext pair c0 = e0 ⊕ (m·h1) and c1 = e1 ⊕ (m·h0) over GF(2)[x]/(x^R−1). Inputs are a dense message polynomial m, the sparse parity-check position lists h0/h1 and the sparse error position lists e0/e1. Because (m·h1)·h0 ⊕ (m·h0)·h1 = 0, the decapsulation syndrome of (c0, c1) equals e0·h0 ⊕ e1·h1. The encaps wrapper feeds the dense e0, e1 and the produced c0, c1 into the existing SHAKE256 KDF path.

---
 rtl/bike_pkg.sv | 29 ++
 rtl/bike_cyclic_rotl.sv | 20 ++
 rtl/bike_encoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bike_pkg.sv
// Shared definitions for the BIKE encoder: default sizes, FSM encoding and
// the packed position-list accessor.
package bike_pkg;

  localparam int unsigned R_DEF     = 127;
  localparam int unsigned W_DEF     = 5;
  localparam int unsigned T_DEF     = 4;
  localparam int unsigned POS_W_DEF = 8;

  // pos_at works on zero-extended lists up to these sizes.
  localparam int unsigned POS_W_MAX = 16;
  localparam int unsigned FLAT_MAX  = 256;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StErr,
    StFin
  } state_e;

  function automatic logic [POS_W_MAX-1:0] pos_at(input logic [FLAT_MAX-1:0] flat,
                                                  input int unsigned         idx,
                                                  input int unsigned         pos_w = POS_W_DEF);
    logic [FLAT_MAX-1:0] sh;
    sh = flat >> (idx * pos_w);
    return sh[POS_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/bike_cyclic_rotl.sv
// Combinational cyclic left rotate of an R-bit vector by p mod R, i.e.
// multiplication by x^p in GF(2)[x]/(x^R-1).
module bike_cyclic_rotl #(
  parameter int unsigned R     = 127,
  parameter int unsigned POS_W = 8
) (
  input  logic [R-1:0]     din,
  input  logic [POS_W-1:0] p,
  output logic [R-1:0]     dout
);

  logic [POS_W-1:0] p_mod;
  logic [2*R-1:0]   dbl;

  assign p_mod = POS_W'(32'(p) % R);
  // Upper half of the doubled vector shifted left is the rotation.
  assign dbl   = {din, din} << p_mod;
  assign dout  = dbl[2*R-1:R];

endmodule

// File: rtl/bike_encoder.sv
// Sequential BIKE encaps encoder: c0 = e0 ^ m*h1, c1 = e1 ^ m*h0 using one
// sparse term per cycle, then the error flips, then the output register.
module bike_encoder
  import bike_pkg::*;
#(
  parameter int unsigned R     = R_DEF,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned T     = T_DEF,
  parameter int unsigned POS_W = POS_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [R-1:0]       m,
  input  logic [W*POS_W-1:0] h0_pos_flat,
  input  logic [W*POS_W-1:0] h1_pos_flat,
  input  logic [T*POS_W-1:0] e0_pos_flat,
  input  logic [T*POS_W-1:0] e1_pos_flat,
  output logic [R-1:0]       c0,
  output logic [R-1:0]       c1,
  output logic [R-1:0]       e0,
  output logic [R-1:0]       e1,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned K_MAX = (W > T) ? W : T;
  localparam int unsigned K_W   = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam logic [K_W-1:0] K_MUL_LAST = K_W'(W - 1);
  localparam logic [K_W-1:0] K_ERR_LAST = K_W'(T - 1);
  // Range limit one bit wider so the compare covers all POS_W bits.
  localparam logic [POS_W:0] R_LIM = (POS_W + 1)'(R);

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [R-1:0]       m_q;
  logic [W*POS_W-1:0] h0_q, h1_q;
  logic [T*POS_W-1:0] e0p_q, e1p_q;
  logic [R-1:0]       acc0_q, acc0_d, acc1_q, acc1_d;
  logic [R-1:0]       e0_q, e0_d, e1_q, e1_d;
  logic [R-1:0]       c0_q, c0_d, c1_q, c1_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               accept;

  logic [POS_W-1:0]   h0_cur, h1_cur, e0_cur, e1_cur;
  logic               h0_ok, h1_ok, e0_ok, e1_ok;
  logic [R-1:0]       rot_h0, rot_h1;

  assign accept = (state_q == StIdle) && start;

  assign h0_cur = POS_W'(pos_at(FLAT_MAX'(h0_q), 32'(k_q), POS_W));
  assign h1_cur = POS_W'(pos_at(FLAT_MAX'(h1_q), 32'(k_q), POS_W));
  assign e0_cur = POS_W'(pos_at(FLAT_MAX'(e0p_q), 32'(k_q), POS_W));
  assign e1_cur = POS_W'(pos_at(FLAT_MAX'(e1p_q), 32'(k_q), POS_W));

  assign h0_ok = {1'b0, h0_cur} < R_LIM;
  assign h1_ok = {1'b0, h1_cur} < R_LIM;
  assign e0_ok = {1'b0, e0_cur} < R_LIM;
  assign e1_ok = {1'b0, e1_cur} < R_LIM;

  bike_cyclic_rotl #(
    .R     (R),
    .POS_W (POS_W)
  ) u_rotl_h0 (
    .din  (m_q),
    .p    (h0_cur),
    .dout (rot_h0)
  );

  bike_cyclic_rotl #(
    .R     (R),
    .POS_W (POS_W)
  ) u_rotl_h1 (
    .din  (m_q),
    .p    (h1_cur),
    .dout (rot_h1)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc0_d  = '0;
          acc1_d  = '0;
          e0_d    = '0;
          e1_d    = '0;
          c0_d    = '0;
          c1_d    = '0;
          err_d   = 1'b0;
          k_d     = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        if (h1_ok) acc0_d = acc0_q ^ rot_h1;
        if (h0_ok) acc1_d = acc1_q ^ rot_h0;
        if (!h0_ok || !h1_ok) err_d = 1'b1;
        if (k_q == K_MUL_LAST) begin
          k_d     = '0;
          state_d = StErr;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      StErr: begin
        // XOR flips: a repeated position cancels itself.
        if (e0_ok) e0_d = e0_q ^ (R'(1) << e0_cur);
        if (e1_ok) e1_d = e1_q ^ (R'(1) << e1_cur);
        if (!e0_ok || !e1_ok) err_d = 1'b1;
        if (k_q == K_ERR_LAST) begin
          state_d = StFin;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      StFin: begin
        c0_d    = acc0_q ^ e0_q;
        c1_d    = acc1_q ^ e1_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q   <= '0;
      h0_q  <= '0;
      h1_q  <= '0;
      e0p_q <= '0;
      e1p_q <= '0;
    end else if (accept) begin
      m_q   <= m;
      h0_q  <= h0_pos_flat;
      h1_q  <= h1_pos_flat;
      e0p_q <= e0_pos_flat;
      e1p_q <= e1_pos_flat;
    end
  end

  assign c0   = c0_q;
  assign c1   = c1_q;
  assign e0   = e0_q;
  assign e1   = e1_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = (state_q != StIdle) || done_q;

endmodule
